argmax_collector: RTL and testbench
===================================

Name: argmax_collector

Overview:
- Sits directly downstream of the scaler and consumes its (output_index, output_value, output_enable) stream.
- Gathers CLASS_COUNT consecutive quantised outputs into one frame and tracks the running maximum and its class position.
- Presents the winning class and its value on a valid/ready result port.
- Also checks that the incoming cell index sequence is consistent with CELL_AMOUNT interleaving.

Parameters:
- DATA_WIDTH, 16, width of the scaled value.
- INDEX_WIDTH, 18, width of the incoming cell index.
- CELL_AMOUNT, 2, number of interleaved systolic cells; the expected index cycles 0..CELL_AMOUNT-1.
- CLASS_COUNT, 10, outputs per frame (≥2).
- CLASS_WIDTH, $clog2(CLASS_COUNT), width of the class position/result; local, derived.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- input_index  input  INDEX_WIDTH  cell index from the scaler.
- input_value  input  DATA_WIDTH  scaled value, unsigned.
- input_enable  input  1  qualifies index/value for this cycle; there is no backpressure upstream.
- result_class  output  CLASS_WIDTH  position of the maximum within the frame.
- result_value  output  DATA_WIDTH  maximum value.
- result_valid  output  1  result held and awaiting consumption.
- result_ready  input  1  downstream accepts the result when result_valid && result_ready.
- overflow  output  1  sticky: a frame completed while the previous result was still unconsumed.
- sequence_error  output  1  sticky: input_index did not match the expected cell index.

Behaviour:
- Reset, synchronous, active-high:
  - All outputs go to 0.
  - Internal position counter, running max, running class and expected index go to 0.
  - Reset asserted mid-frame discards the partial frame and any held result.
- Collect path, on every edge where input_enable=1:
  - pos: 0..CLASS_COUNT-1.
  - On pos==0, running max is loaded unconditionally with input_value and class with 0.
  - On pos>0, the running max/class are replaced only if input_value > running max. This is a strict compare, so ties keep the lowest position.
  - pos increments and wraps to 0 after CLASS_COUNT-1.
  - The expected index increments modulo CELL_AMOUNT.
  - input_enable=0: nothing changes; gaps of any length between elements are legal.
- Frame completion, accepted element with pos==CLASS_COUNT-1:
  - The final max/class includes that element, compared in the same cycle.
  - If the holding register is empty, or is being drained this same cycle (result_valid && result_ready), load result_class/result_value and set result_valid=1 on that edge.
  - Latency is one clock from the last element's edge to result_valid.
  - If the holding register is full and not draining, the new result is dropped, the held result is kept and overflow is set.
- Output holding register, states EMPTY/FULL:
  - EMPTY→FULL on frame completion.
  - FULL→EMPTY on result_ready with no simultaneous completion.
  - FULL→FULL with new data on simultaneous drain and completion.
  - result_class/result_value are stable while result_valid=1.
- Sequence check:
  - If input_enable=1 and input_index ≠ expected index, set sequence_error.
  - The value is still used, and the expected index resyncs to (input_index+1) mod CELL_AMOUNT.
  - An input_index ≥ CELL_AMOUNT also flags the error and resyncs the expected index to 0.
- Sticky flags are cleared only by reset.
- Arithmetic: unsigned compares only; no width growth; pos counter is CLASS_WIDTH bits.

Optional Feature:
- Macro: ARGMAX_COLLECTOR_SECOND_EN.
- When defined:
  - Extra outputs second_class (CLASS_WIDTH) and second_value (DATA_WIDTH) carry the runner-up.
  - Runner-up updates: a new max demotes the old max to second; otherwise a value > second replaces it. Ties keep the earlier element.
  - pos==0 initialises second_value to 0 and second_class to 0.
  - Both are loaded and held alongside result_* under the same valid/ready rules.
- When undefined: these ports and their registers do not exist, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Default DATA_WIDTH/INDEX_WIDTH/CELL_AMOUNT/CLASS_COUNT constants, shared with the scaler instantiation.
  - A result struct typedef {class, value}.
- One sub-module is natural: result_holding_reg, a one-entry valid/ready register with a drop-on-full overflow output, reusable for other single-result stages.

Test Plan:
- Single frame, CELL_AMOUNT=2, CLASS_COUNT=10, values 5,35,10,25,99,3,99,7,0,12 with indices alternating 0,1 → one clock after the 10th element: result_valid=1, result_class=4, result_value=99, sequence_error=0.
- Same frame with input_enable gaps of 0–3 cycles and result_ready held low for 5 cycles → result stable throughout; result_valid drops the cycle after result_ready=1.
- Second frame completes while the first is unconsumed (result_ready=0) → overflow=1; first result (class 4, value 99) retained.
- Drain and completion in the same cycle → result_valid stays 1 and the new frame's result is loaded; overflow=0.
- Index sequence 0,1,1,0 → sequence_error=1 on the third element; the fourth element (index 0) causes no further mismatch; argmax still correct.
- Reset asserted after 6 elements, then a full frame of all-equal values 7 → result_class=0, result_value=7; no stale data from the partial frame. With the macro defined: second_class=1, second_value=7.

Source files
------------

// File: rtl/argmax_collector_pkg.sv
// ============================================================================
// Module      : argmax_collector_pkg
// Description : Shared default sizes for the scaler -> argmax chain and the
//               result record type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package argmax_collector_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_INDEX_WIDTH = 18;
  localparam int DEF_CELL_AMOUNT = 2;
  localparam int DEF_CLASS_COUNT = 10;
  localparam int DEF_CLASS_WIDTH = $clog2(DEF_CLASS_COUNT);

  // Winning class position and its value for a default-sized frame.
  typedef struct packed {
    logic [DEF_CLASS_WIDTH-1:0] cls;
    logic [DEF_DATA_WIDTH-1:0]  value;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/argmax_collector_if.sv
// ============================================================================
// Module      : argmax_collector_if
// Description : Input stream from the scaler plus the valid/ready result port
//               and status flags of the argmax collector.
//               ARGMAX_COLLECTOR_SECOND_EN adds the runner-up signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface argmax_collector_if #(
  parameter int DATA_WIDTH  = argmax_collector_pkg::DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = argmax_collector_pkg::DEF_INDEX_WIDTH,
  parameter int CLASS_COUNT = argmax_collector_pkg::DEF_CLASS_COUNT
) ();

  localparam int CLASS_WIDTH = $clog2(CLASS_COUNT);

  logic [INDEX_WIDTH-1:0] input_index;
  logic [DATA_WIDTH-1:0]  input_value;
  logic                   input_enable;
  logic [CLASS_WIDTH-1:0] result_class;
  logic [DATA_WIDTH-1:0]  result_value;
  logic                   result_valid;
  logic                   result_ready;
  logic                   overflow;
  logic                   sequence_error;
`ifdef ARGMAX_COLLECTOR_SECOND_EN
  logic [CLASS_WIDTH-1:0] second_class;
  logic [DATA_WIDTH-1:0]  second_value;
`endif

  // Upstream/downstream side: drives the stream and consumes the result.
  modport master (
    output input_index, input_value, input_enable, result_ready,
    input  result_class, result_value, result_valid, overflow, sequence_error
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    , input second_class, second_value
`endif
  );

  // Collector side.
  modport slave (
    input  input_index, input_value, input_enable, result_ready,
    output result_class, result_value, result_valid, overflow, sequence_error
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    , output second_class, second_value
`endif
  );

endinterface

`default_nettype wire

// File: rtl/argmax_collector_holding.sv
// ============================================================================
// Module      : result_holding_reg
// Description : One-entry valid/ready holding register. A load arriving while
//               full and not draining is dropped and flagged by a sticky
//               overflow bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_holding_reg
  import argmax_collector_pkg::*;
#(
  parameter int WIDTH = DEF_CLASS_WIDTH + DEF_DATA_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_ready,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overflow
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_overflow;
  logic             w_accept;

  // A load is taken when there is room, including room freed by a drain this cycle.
  assign w_accept = i_load && ((r_state == S_EMPTY) || i_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Next state: a load always leaves us full; a drain alone empties us.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (i_load)  w_state_nxt = S_FULL;
      S_FULL:  if (!i_load && i_ready) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output decode.
  always_comb begin
    o_valid = (r_state == S_FULL);
  end

  // Payload only changes on an accepted load, so it is stable while valid.
  always_ff @(posedge clk) begin
    if (reset)         r_data <= '0;
    else if (w_accept) r_data <= i_data;
  end

  // Sticky flag for a result dropped because the entry was occupied.
  always_ff @(posedge clk) begin
    if (reset)                                        r_overflow <= 1'b0;
    else if (i_load && (r_state == S_FULL) && !i_ready) r_overflow <= 1'b1;
  end

  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/argmax_collector.sv
// ============================================================================
// Module      : argmax_collector
// Description : Collects CLASS_COUNT scaled outputs per frame, tracks the
//               running maximum and its position, and presents the winner on
//               a valid/ready port. Checks the cell index interleaving.
//               Optional macro ARGMAX_COLLECTOR_SECOND_EN adds the runner-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_collector
  import argmax_collector_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int CELL_AMOUNT = DEF_CELL_AMOUNT,
  parameter int CLASS_COUNT = DEF_CLASS_COUNT
) (
  input  wire logic          clk,
  input  wire logic          reset,
  argmax_collector_if.slave  bus
);

  localparam int CLASS_WIDTH = $clog2(CLASS_COUNT);
  localparam logic [CLASS_WIDTH-1:0] c_POS_LAST = CLASS_WIDTH'(CLASS_COUNT - 1);
  localparam logic [INDEX_WIDTH-1:0] c_IDX_LAST = INDEX_WIDTH'(CELL_AMOUNT - 1);
  localparam int c_ONE_W = CLASS_WIDTH + DATA_WIDTH;
`ifdef ARGMAX_COLLECTOR_SECOND_EN
  localparam int c_RES_W = 2 * c_ONE_W;
`else
  localparam int c_RES_W = c_ONE_W;
`endif

  logic [CLASS_WIDTH-1:0] r_pos;
  logic [DATA_WIDTH-1:0]  r_max;
  logic [CLASS_WIDTH-1:0] r_cls;
  logic [INDEX_WIDTH-1:0] r_exp_idx;
  logic                   r_seq_err;

  logic                   w_first;
  logic                   w_last;
  logic                   w_win;
  logic [DATA_WIDTH-1:0]  w_max;
  logic [CLASS_WIDTH-1:0] w_cls;
  logic [INDEX_WIDTH-1:0] w_exp_nxt;
  logic                   w_idx_bad;
  logic                   w_load;
  logic [c_RES_W-1:0]     w_res_in;
  logic [c_RES_W-1:0]     w_res_out;

  assign w_first = (r_pos == '0);
  assign w_last  = (r_pos == c_POS_LAST);
  assign w_win   = (bus.input_value > r_max);

  // Max/class including the current element, so the last element of a frame
  // is already folded in when the result is loaded.
  always_comb begin
    w_max = r_max;
    w_cls = r_cls;
    if (w_first || w_win) begin
      w_max = bus.input_value;
      w_cls = r_pos;
    end
  end

`ifdef ARGMAX_COLLECTOR_SECOND_EN
  logic [DATA_WIDTH-1:0]  r_sec;
  logic [CLASS_WIDTH-1:0] r_sec_cls;
  logic [DATA_WIDTH-1:0]  w_sec;
  logic [CLASS_WIDTH-1:0] w_sec_cls;

  // Runner-up: a new max demotes the old one, otherwise a strictly larger value wins.
  always_comb begin
    w_sec     = r_sec;
    w_sec_cls = r_sec_cls;
    if (w_first) begin
      w_sec     = '0;
      w_sec_cls = '0;
    end else if (w_win) begin
      w_sec     = r_max;
      w_sec_cls = r_cls;
    end else if (bus.input_value > r_sec) begin
      w_sec     = bus.input_value;
      w_sec_cls = r_pos;
    end
  end

  // Runner-up registers advance with every accepted element.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec     <= '0;
      r_sec_cls <= '0;
    end else if (bus.input_enable) begin
      r_sec     <= w_sec;
      r_sec_cls <= w_sec_cls;
    end
  end

  assign w_res_in = {w_sec_cls, w_sec, w_cls, w_max};
  assign bus.second_class = w_res_out[c_RES_W-1 -: CLASS_WIDTH];
  assign bus.second_value = w_res_out[c_ONE_W +: DATA_WIDTH];
`else
  assign w_res_in = {w_cls, w_max};
`endif

  // Frame position and running max advance on every accepted element.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos <= '0;
      r_max <= '0;
      r_cls <= '0;
    end else if (bus.input_enable) begin
      r_pos <= w_last ? '0 : r_pos + 1'b1;
      r_max <= w_max;
      r_cls <= w_cls;
    end
  end

  // Expected index always resyncs from the observed one; matching indices
  // give the same result as simply incrementing.
  assign w_idx_bad = (bus.input_index > c_IDX_LAST);
  always_comb begin
    w_exp_nxt = bus.input_index + 1'b1;
    if (w_idx_bad || (bus.input_index == c_IDX_LAST)) w_exp_nxt = '0;
  end

  // Interleave check with a sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp_idx <= '0;
      r_seq_err <= 1'b0;
    end else if (bus.input_enable) begin
      r_exp_idx <= w_exp_nxt;
      if (w_idx_bad || (bus.input_index != r_exp_idx)) r_seq_err <= 1'b1;
    end
  end

  assign w_load = bus.input_enable && w_last;

  result_holding_reg #(
    .WIDTH (c_RES_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_res_in),
    .i_ready    (bus.result_ready),
    .o_data     (w_res_out),
    .o_valid    (bus.result_valid),
    .o_overflow (bus.overflow)
  );

  assign bus.result_value   = w_res_out[0 +: DATA_WIDTH];
  assign bus.result_class   = w_res_out[DATA_WIDTH +: CLASS_WIDTH];
  assign bus.sequence_error = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_argmax_collector.sv
// ============================================================================
// Module      : tb_argmax_collector
// Description : Directed bench for argmax_collector with hand-computed
//               expectations. Runner-up checks follow
//               ARGMAX_COLLECTOR_SECOND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argmax_collector;
  import argmax_collector_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  argmax_collector_if u_if ();

  argmax_collector u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int next_idx = 0;

  int FRAME_A [10] = '{5, 35, 10, 25, 99, 3, 99, 7, 0, 12};
  int FRAME_B [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int FRAME_C [10] = '{20, 80, 30, 80, 10, 0, 0, 0, 0, 40};
  int FRAME_S [10] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
  int IDX_S   [10] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
  int FRAME_Z [10] = '{200, 201, 202, 203, 204, 205, 0, 0, 0, 0};

  result_t exp_a = '{cls: 4'd4, value: 16'd99};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    next_idx = 0;
  endtask

  task automatic send(input int idx, input int val);
    u_if.input_index  = 18'(idx);
    u_if.input_value  = 16'(val);
    u_if.input_enable = 1'b1;
    idle(1);
    u_if.input_enable = 1'b0;
  endtask

  task automatic send_elems(input int v [10], input int lo, input int hi, input int gapmax);
    for (int i = lo; i <= hi; i++) begin
      send(next_idx, v[i]);
      next_idx = (next_idx + 1) % 2;
      if (gapmax > 0) idle(i % (gapmax + 1));
    end
  endtask

  initial begin
    reset             = 1'b1;
    u_if.input_index  = '0;
    u_if.input_value  = '0;
    u_if.input_enable = 1'b0;
    u_if.result_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_valid", u_if.result_valid, 0);
    check("rst_class", u_if.result_class, 0);
    check("rst_value", u_if.result_value, 0);
    check("rst_ovf", u_if.overflow, 0);
    check("rst_seqerr", u_if.sequence_error, 0);

    // Single frame, one-clock latency
    send_elems(FRAME_A, 0, 8, 0);
    check("a_valid_before_last", u_if.result_valid, 0);
    send_elems(FRAME_A, 9, 9, 0);
    check("a_valid", u_if.result_valid, 1);
    check("a_class", u_if.result_class, exp_a.cls);
    check("a_value", u_if.result_value, exp_a.value);
    check("a_seqerr", u_if.sequence_error, 0);
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    check("a_sec_class", u_if.second_class, 6);
    check("a_sec_value", u_if.second_value, 99);
`endif
    for (int c = 0; c < 5; c++) begin
      idle(1);
      check("a_hold_valid", u_if.result_valid, 1);
      check("a_hold_class", u_if.result_class, 4);
      check("a_hold_value", u_if.result_value, 99);
    end
    u_if.result_ready = 1'b1;
    idle(1);
    u_if.result_ready = 1'b0;
    check("a_drained", u_if.result_valid, 0);

    // Same frame with gaps, then overflow from an unconsumed result
    send_elems(FRAME_A, 0, 9, 3);
    check("gap_valid", u_if.result_valid, 1);
    check("gap_class", u_if.result_class, 4);
    check("gap_value", u_if.result_value, 99);
    check("gap_ovf", u_if.overflow, 0);
    send_elems(FRAME_B, 0, 9, 0);
    check("ovf_flag", u_if.overflow, 1);
    check("ovf_valid", u_if.result_valid, 1);
    check("ovf_keep_class", u_if.result_class, 4);
    check("ovf_keep_value", u_if.result_value, 99);

    // Drain and completion in the same cycle
    do_reset();
    check("rst2_ovf", u_if.overflow, 0);
    check("rst2_valid", u_if.result_valid, 0);
    send_elems(FRAME_A, 0, 9, 0);
    send_elems(FRAME_C, 0, 8, 0);
    u_if.result_ready = 1'b1;
    send_elems(FRAME_C, 9, 9, 0);
    u_if.result_ready = 1'b0;
    check("dc_valid", u_if.result_valid, 1);
    check("dc_class", u_if.result_class, 1);
    check("dc_value", u_if.result_value, 80);
    check("dc_ovf", u_if.overflow, 0);
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    check("dc_sec_class", u_if.second_class, 3);
    check("dc_sec_value", u_if.second_value, 80);
`endif
    u_if.result_ready = 1'b1;
    idle(1);
    u_if.result_ready = 1'b0;
    check("dc_drained", u_if.result_valid, 0);

    // Index sequence 0,1,1,0,...
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(IDX_S[i], FRAME_S[i]);
      if (i == 1) check("seq_ok_2nd", u_if.sequence_error, 0);
      if (i == 2) check("seq_err_3rd", u_if.sequence_error, 1);
    end
    check("seq_valid", u_if.result_valid, 1);
    check("seq_class", u_if.result_class, 5);
    check("seq_value", u_if.result_value, 9);
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    check("seq_sec_class", u_if.second_class, 7);
    check("seq_sec_value", u_if.second_value, 6);
`endif

    // Out-of-range index
    do_reset();
    check("oor_clear", u_if.sequence_error, 0);
    send(3, 1);
    check("oor_err", u_if.sequence_error, 1);

    // Reset mid-frame with a held result, then an all-equal frame
    do_reset();
    send_elems(FRAME_A, 0, 9, 0);
    send_elems(FRAME_Z, 0, 5, 0);
    do_reset();
    check("mid_valid", u_if.result_valid, 0);
    check("mid_value", u_if.result_value, 0);
    for (int i = 0; i < 10; i++) begin
      send(next_idx, 7);
      next_idx = (next_idx + 1) % 2;
    end
    check("eq_valid", u_if.result_valid, 1);
    check("eq_class", u_if.result_class, 0);
    check("eq_value", u_if.result_value, 7);
    check("eq_seqerr", u_if.sequence_error, 0);
`ifdef ARGMAX_COLLECTOR_SECOND_EN
    check("eq_sec_class", u_if.second_class, 1);
    check("eq_sec_value", u_if.second_value, 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
